// File: rtl/mux4x1_sched_pkg.sv
// Shared definitions for the 4-lane byte scheduler: FSM states, lane count
// and the COM idle symbol.
package mux_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_t;

  localparam int          LANES   = 4;
  localparam logic [7:0]  COM_SYM = 8'hBC;

endpackage

// File: rtl/mux4x1_sched_if.sv
// Bus bundle for mux4x1_sched: lane inputs, load/hold controls and the
// emitted byte stream with status.
//
// Handshake: a group is transferred on a rising edge where load && ready.
// ready is combinational. hold stalls emission; while hold is high in SEND
// nothing advances and no group is accepted.
interface mux4x1_sched_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [3:0]       valid;
  logic             load;
  logic             hold;
  logic             ready;
  logic [WIDTH-1:0] out;
  logic             validout;
  logic [1:0]       lane;
  logic             busy;
  logic [7:0]       drop_cnt;

  // Scheduler side.
  modport slave (
    input  in0, in1, in2, in3, valid, load, hold,
    output ready, out, validout, lane, busy, drop_cnt
  );

  // Producer / consumer side.
  modport master (
    output in0, in1, in2, in3, valid, load, hold,
    input  ready, out, validout, lane, busy, drop_cnt
  );
endinterface

// File: rtl/mux4x1_sched_lane_pick4.sv
// Lowest-set-bit encoder for a 4-bit lane mask, also reporting whether any
// bit is set and whether exactly one bit is set.
module lane_pick4 (
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       any,
  output logic       onehot
);

  // Priority-encode the lowest pending lane and classify the mask.
  always_comb begin
    idx    = 2'd0;
    any    = |mask;
    onehot = 1'b0;
    casez (mask)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: onehot = 1'b1;
      default:                            onehot = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux4x1_sched.sv
// mux4x1_sched: captures a group of four lane bytes with a valid mask and
// emits the valid bytes one per clock in ascending lane order.
// Optional macro MUX4X1_SCHED_IDLE_SYM_EN: drive the COM symbol on out
// during reset, idle and hold cycles instead of 0 / last value.
// busy mirrors the FSM state register (1 = SEND) for observation.
module mux4x1_sched
  import mux_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  mux4x1_sched_if.slave   bus
);

`ifdef MUX4X1_SCHED_IDLE_SYM_EN
  localparam logic [WIDTH-1:0] IDLE_OUT = WIDTH'(COM_SYM);
`else
  localparam logic [WIDTH-1:0] IDLE_OUT = '0;
`endif

  sched_state_t     state_q, state_d;
  logic [3:0]       pending_q, pending_d;
  logic [WIDTH-1:0] data_q [LANES];
  logic [WIDTH-1:0] in_w   [LANES];
  logic [WIDTH-1:0] out_q;
  logic             validout_q;
  logic [1:0]       lane_q;
  logic [7:0]       drop_q;

  logic [1:0]       idx;
  logic             any;
  logic             onehot;
  logic             ready_c;
  logic             accept;
  logic             emit;

  assign in_w[0] = bus.in0;
  assign in_w[1] = bus.in1;
  assign in_w[2] = bus.in2;
  assign in_w[3] = bus.in3;

  lane_pick4 u_pick (
    .mask   (pending_q),
    .idx    (idx),
    .any    (any),
    .onehot (onehot)
  );

  // A new group fits when idle, or when the byte leaving this edge is the last.
  assign ready_c = (state_q == IDLE) || (onehot && !bus.hold);
  assign accept  = bus.load && ready_c;
  assign emit    = (state_q == SEND) && !bus.hold && any;

  // Next-state and pending-mask update.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pending_d = bus.valid;
          state_d   = (|bus.valid) ? SEND : IDLE;
        end
      end
      SEND: begin
        if (emit) begin
          pending_d = pending_q & ~(4'b0001 << idx);
          // accept in SEND implies this emit drains the last pending lane
          if (accept) begin
            pending_d = bus.valid;
            state_d   = (|bus.valid) ? SEND : IDLE;
          end else if (onehot) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 4'b0000;
      end
    endcase
  end

  // State, pending mask and refused-load counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (bus.load && !ready_c && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Lane data capture on an accepted load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) data_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) data_q[i] <= in_w[i];
    end
  end

  // Registered output byte, lane index and valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= IDLE_OUT;
      validout_q <= 1'b0;
      lane_q     <= 2'd0;
    end else if (state_q == IDLE) begin
      out_q      <= IDLE_OUT;
      validout_q <= 1'b0;
      lane_q     <= 2'd0;
    end else if (emit) begin
      out_q      <= data_q[idx];
      validout_q <= 1'b1;
      lane_q     <= idx;
    end else begin
      validout_q <= 1'b0;
`ifdef MUX4X1_SCHED_IDLE_SYM_EN
      out_q      <= IDLE_OUT;
`endif
    end
  end

  assign bus.ready    = ready_c;
  assign bus.out      = out_q;
  assign bus.validout = validout_q;
  assign bus.lane     = lane_q;
  assign bus.busy     = (state_q == SEND);
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_mux4x1_sched.sv
// Bench for mux4x1_sched: directed scenarios plus random traffic, compared
// cycle by cycle against a queue-based model of the byte stream.
module tb_mux4x1_sched;

`ifdef MUX4X1_SCHED_IDLE_SYM_EN
  localparam logic [7:0] IDLE_V = 8'hBC;
`else
  localparam logic [7:0] IDLE_V = 8'h00;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux4x1_sched_if #(.WIDTH(8)) bus ();

  mux4x1_sched #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];   // {lane, byte} still owed by the block
  logic [7:0] m_out;
  logic       m_vout;
  logic [1:0] m_lane;
  int         m_drop;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  task automatic check_outputs();
    check("validout", 32'(bus.validout), 32'(m_vout));
    check("lane", 32'(bus.lane), 32'(m_lane));
    check("out", 32'(bus.out), 32'(m_out));
    check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
    check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.hold  = 1'b0;
    bus.valid = 4'h0;
    @(posedge clk);
    exp_q.delete();
    m_out  = IDLE_V;
    m_vout = 1'b0;
    m_lane = 2'd0;
    m_drop = 0;
    #1;
    check_outputs();
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic step(input logic ld, input logic [3:0] vm, input logic [31:0] d, input logic hd);
    logic       m_ready;
    logic [9:0] ent;
    @(negedge clk);
    reset     = 1'b0;
    bus.load  = ld;
    bus.valid = vm;
    bus.in0   = d[7:0];
    bus.in1   = d[15:8];
    bus.in2   = d[23:16];
    bus.in3   = d[31:24];
    bus.hold  = hd;
    #1;
    m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && !hd);
    check("ready", 32'(bus.ready), 32'(m_ready));
    @(posedge clk);
    if (ld && !m_ready && m_drop < 255) m_drop++;
    if (exp_q.size() == 0) begin
      m_vout = 1'b0;
      m_lane = 2'd0;
      m_out  = IDLE_V;
    end else if (hd) begin
      m_vout = 1'b0;
`ifdef MUX4X1_SCHED_IDLE_SYM_EN
      m_out  = IDLE_V;
`endif
    end else begin
      ent    = exp_q.pop_front();
      m_vout = 1'b1;
      m_lane = ent[9:8];
      m_out  = ent[7:0];
    end
    if (ld && m_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (vm[i]) exp_q.push_back({2'(i), d[8*i +: 8]});
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, $urandom, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.load  = 1'b0;
    bus.hold  = 1'b0;
    bus.valid = 4'h0;
    bus.in0   = 8'h00;
    bus.in1   = 8'h00;
    bus.in2   = 8'h00;
    bus.in3   = 8'h00;

    do_reset();
    idle(1);

    // full group in lane order
    step(1'b1, 4'hF, 32'h44332211, 1'b0);
    idle(5);

    // sparse mask 1010
    step(1'b1, 4'b1010, 32'hA300A100, 1'b0);
    idle(3);

    // back-to-back: second group loaded on the last byte of the first
    step(1'b1, 4'hF, 32'hD4C3B2A1, 1'b0);
    idle(3);
    step(1'b1, 4'h1, 32'h0000005A, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b0);
    check("b2b_5a_valid", 32'(bus.validout), 32'd1);
    check("b2b_5a_out", 32'(bus.out), 32'h5A);
    idle(2);

    // hold for 3 cycles mid-group
    step(1'b1, 4'hF, 32'h87654321, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 32'h0, 1'b1);
    idle(5);

    // load held through a group, then saturate drop_cnt
    do_reset();
    step(1'b1, 4'hF, 32'h0F0E0D0C, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 32'h0F0E0D0C, 1'b0);
    check("drop_three", 32'(bus.drop_cnt), 32'd3);
    for (int i = 0; i < 300; i++) step(1'b1, 4'hF, $urandom, 1'b1);
    check("drop_sat", 32'(bus.drop_cnt), 32'd255);
    idle(6);

    // reset after the 2nd byte of a group
    do_reset();
    step(1'b1, 4'hF, 32'h99887766, 1'b0);
    idle(2);
    do_reset();
    idle(3);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 40, 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 99) < 20);
      end
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4x1_sched.md
# mux4x1_sched

Lane scheduler for the 4-lane byte striping path. Captures one group of four 8-bit lane bytes with a 4-bit valid mask. Emits the valid bytes one per clock, in ascending lane order, skipping invalid lanes. Sits in front of the serializer and replaces the fixed-rate 4f/2f/1f clock-ratio muxing with a single-clock, handshaked, compacting sequencer.

## Interface
Parameters:
- WIDTH, 8, byte width per lane; lane count is fixed at 4.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in0..in3  in  WIDTH  lane data, sampled only on an accepted load.
- valid  in  4  per-lane valid; valid[i] qualifies in_i.
- load  in  1  offer of a new group; accepted when load && ready at a rising edge.
- hold  in  1  downstream stall; freezes sequencing.
- ready  out  1  combinational; block can accept a group this cycle.
- out  out  WIDTH  registered emitted byte.
- validout  out  1  registered; out carries a lane byte this cycle.
- lane  out  2  registered index of the lane currently on out.
- busy  out  1  registered; state is SEND.
- drop_cnt  out  8  registered count of loads refused (load && !ready), saturating at 255.

## Operation
- State machine with two states: IDLE and SEND. Internal state is a 4×WIDTH data register and a 4-bit pending mask.
- Capture, on an accepted load:
  - data register <= in0..in3; pending <= valid.
  - If valid == 4'b0000, the load is consumed and nothing is queued: the block enters or stays in IDLE.
  - If any bit is set, state <= SEND.
- Emit, in SEND with hold = 0: each edge selects idx = the lowest set bit of pending, then:
  - out <= data[idx], validout <= 1, lane <= idx;
  - clears pending[idx].
  - When the cleared bit was the last one and no load is accepted on that edge, state <= IDLE.
- Hold, with hold = 1 in SEND:
  - pending, state and data are frozen; validout <= 0; out and lane keep their previous values.
  - ready = 0 while hold = 1 in SEND.
- ready = (state == IDLE) || (popcount(pending) == 1 && !hold).
  - This allows a gapless back-to-back group: the load is accepted on the edge that emits the last pending byte, and the next edge emits the first byte of the new group.
- In IDLE: validout <= 0 and lane <= 0. out behaviour depends on the Configuration macro.
- drop_cnt increments on every edge with load && !ready. It saturates at 8'hFF and is cleared only by reset.

## Timing
- Reset values: ready = 1 (combinationally, from IDLE); validout = 0; lane = 0; busy = 0; drop_cnt = 0; pending = 0; out as defined under Configuration.
- Latency: a group accepted at edge k has its first byte on out after edge k+1. The n-th valid lane appears after edge k+n, with hold low throughout.
- Group duration equals popcount(valid) cycles, plus one cycle per hold-high cycle.
- Simultaneous load and last emit: both occur on the same edge; busy stays 1.
- Reset mid-group: pending is discarded and no further bytes of that group are emitted. ready = 1 in the cycle after the reset edge.
- hold in IDLE has no effect; the load is still accepted.

## Configuration
- MUX4X1_SCHED_IDLE_SYM_EN.
  - Defined: out is driven to the PCIe COM symbol 8'hBC in reset and on every IDLE/hold cycle that has validout = 0, giving the serializer a symbol-aligned idle pattern.
  - Undefined: out resets to 8'h00, stays 8'h00 on IDLE cycles, and holds its last value during hold.

## Structure
- Shared package mux_sched_pkg holds:
  - the state enum (IDLE, SEND);
  - constant LANES = 4;
  - constant COM_SYM = 8'hBC.
- Sub-module lane_pick4: combinational lowest-set-bit encoder. Takes a 4-bit mask and returns idx[1:0], any and onehot (popcount == 1).

## Test plan
- Reset, then load in0..3 = 8'h11/22/33/44 with valid = 4'hF: out = 11, 22, 33, 44 on 4 consecutive cycles after edge k+1; lane = 0..3; busy drops afterwards.
- valid = 4'b1010 with in1 = 8'hA1 and in3 = 8'hA3: exactly 2 bytes, A1 (lane 1) then A3 (lane 3); ready rises during the A1 cycle.
- Back-to-back: second group (valid = 4'h1, in0 = 8'h5A) loaded while ready is high on the last byte of the first group: 8'h5A follows with no validout gap.
- hold high for 3 cycles mid-group: validout = 0 for those 3 cycles; no byte lost or duplicated; total duration grows by 3.
- load held high through an entire 4-lane group: drop_cnt = 3. Then force 300 refused loads: drop_cnt saturates at 255.
- Reset asserted after the 2nd byte of a 4-lane group: no further bytes; validout = 0; ready = 1 on the next cycle. Under MUX4X1_SCHED_IDLE_SYM_EN, out = 8'hBC.
